// File: rtl/floo_axis_bridge_arbiter.sv
// Multiplexes chimney req/rsp flits onto one AXI-Stream link (hdr MSB: 0=req, 1=rsp) using quota-based
// round-robin and per-channel far-end credits. Optional beat/stall counters: FLOO_BRIDGE_ARB_STATS_EN.

module floo_axis_bridge_arbiter_chk #(
  parameter int unsigned MaxCredits = 8,
  parameter int unsigned CntW       = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            i_req_credit,
  input  logic            i_req_grant,
  input  logic [CntW-1:0] i_req_credits,
  input  logic            i_rsp_credit,
  input  logic            i_rsp_grant,
  input  logic [CntW-1:0] i_rsp_credits
);
  localparam logic [CntW-1:0] CredMax = CntW'(MaxCredits);

  // A credit returned while the counter is already full means the far end freed a slot it never held.
  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(i_req_credit && !i_req_grant && (i_req_credits == CredMax)))
        else $warning("protocol error: req credit pulse while counter full");
      assert (!(i_rsp_credit && !i_rsp_grant && (i_rsp_credits == CredMax)))
        else $warning("protocol error: rsp credit pulse while counter full");
    end
  end
endmodule

module floo_axis_bridge_arbiter #(
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned ReqQuota   = 4,
  parameter int unsigned RspQuota   = 4,
  parameter int unsigned MaxCredits = 8,
  parameter int unsigned CntW       = $clog2(MaxCredits + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [DataWidth-1:0] req_data_i,
  input  logic                 rsp_valid_i,
  output logic                 rsp_ready_o,
  input  logic [DataWidth-1:0] rsp_data_i,
  output logic                 axis_tvalid_o,
  input  logic                 axis_tready_i,
  output logic [DataWidth:0]   axis_tdata_o,
  input  logic                 req_credit_i,
  input  logic                 rsp_credit_i,
  output logic [CntW-1:0]      req_credits_o,
  output logic [CntW-1:0]      rsp_credits_o
`ifdef FLOO_BRIDGE_ARB_STATS_EN
  ,
  output logic [31:0]          stat_req_beats_o,
  output logic [31:0]          stat_rsp_beats_o,
  output logic [31:0]          stat_credit_stall_o
`endif
);
  localparam int unsigned MaxQuota = (ReqQuota > RspQuota) ? ReqQuota : RspQuota;
  localparam int unsigned BurstW   = $clog2(MaxQuota + 1);

  localparam logic [BurstW-1:0] ReqQuotaB = BurstW'(ReqQuota);
  localparam logic [BurstW-1:0] RspQuotaB = BurstW'(RspQuota);
  localparam logic [BurstW-1:0] BurstMax  = BurstW'(MaxQuota);
  localparam logic [CntW-1:0]   CredMax   = CntW'(MaxCredits);
  localparam logic [CntW-1:0]   CredZero  = {CntW{1'b0}};
  localparam logic              ChReq     = 1'b0;
  localparam logic              ChRsp     = 1'b1;

  logic                 r_owner;
  logic                 w_owner_nxt;
  logic [BurstW-1:0]    r_burst_cnt;
  logic [BurstW-1:0]    w_burst_nxt;
  logic [CntW-1:0]      r_req_cred;
  logic [CntW-1:0]      r_rsp_cred;
  logic                 r_tvalid;
  logic [DataWidth:0]   r_tdata;
  logic                 w_load_en;
  logic                 w_req_elig;
  logic                 w_rsp_elig;
  logic                 w_grant_vld;
  logic                 w_grant_ch;
  logic [DataWidth-1:0] w_grant_data;

  function automatic logic [CntW-1:0] f_cred_nxt(input logic [CntW-1:0] cnt,
                                                 input logic            dec,
                                                 input logic            inc);
    logic [CntW-1:0] res;
    res = cnt;
    if (dec && !inc) begin
      res = cnt - CntW'(1);
    end else if (inc && !dec && (cnt != CredMax)) begin
      res = cnt + CntW'(1);
    end else begin
      res = cnt;
    end
    return res;
  endfunction

  assign w_load_en    = !r_tvalid || axis_tready_i;
  assign w_req_elig   = req_valid_i && (r_req_cred != CredZero);
  assign w_rsp_elig   = rsp_valid_i && (r_rsp_cred != CredZero);
  assign w_grant_data = (w_grant_ch == ChRsp) ? rsp_data_i : req_data_i;

  // Grant decision: the current owner keeps the link until its quota is used while the other is eligible.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_ch  = ChReq;
    if (rst_i || !w_load_en) begin
      w_grant_vld = 1'b0;
    end else if (w_req_elig && w_rsp_elig) begin
      w_grant_vld = 1'b1;
      if (r_owner == ChReq) begin
        w_grant_ch = (r_burst_cnt < ReqQuotaB) ? ChReq : ChRsp;
      end else begin
        w_grant_ch = (r_burst_cnt < RspQuotaB) ? ChRsp : ChReq;
      end
    end else if (w_req_elig) begin
      w_grant_vld = 1'b1;
      w_grant_ch  = ChReq;
    end else if (w_rsp_elig) begin
      w_grant_vld = 1'b1;
      w_grant_ch  = ChRsp;
    end else begin
      w_grant_vld = 1'b0;
    end
  end

  // Owner / burst-count next state; idle cycles hold both.
  always_comb begin
    w_owner_nxt = r_owner;
    w_burst_nxt = r_burst_cnt;
    if (!w_grant_vld) begin
      w_owner_nxt = r_owner;
    end else if (w_grant_ch == r_owner) begin
      w_burst_nxt = (r_burst_cnt == BurstMax) ? r_burst_cnt : r_burst_cnt + BurstW'(1);
    end else begin
      w_owner_nxt = w_grant_ch;
      w_burst_nxt = BurstW'(1);
    end
  end

  // Owner / burst-count state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_owner     <= ChReq;
      r_burst_cnt <= {BurstW{1'b0}};
    end else begin
      r_owner     <= w_owner_nxt;
      r_burst_cnt <= w_burst_nxt;
    end
  end

  // Handshake outputs toward the chimney.
  always_comb begin
    req_ready_o = w_grant_vld && (w_grant_ch == ChReq);
    rsp_ready_o = w_grant_vld && (w_grant_ch == ChRsp);
  end

  // Credit counters: a grant consumes a far-end slot, a credit pulse returns one.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_req_cred <= CredMax;
      r_rsp_cred <= CredMax;
    end else begin
      r_req_cred <= f_cred_nxt(r_req_cred, req_ready_o, req_credit_i);
      r_rsp_cred <= f_cred_nxt(r_rsp_cred, rsp_ready_o, rsp_credit_i);
    end
  end

  // Link output register; holds while the beat is pending and tready is low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tvalid <= 1'b0;
      r_tdata  <= {(DataWidth + 1){1'b0}};
    end else if (w_load_en) begin
      r_tvalid <= w_grant_vld;
      r_tdata  <= w_grant_vld ? {w_grant_ch, w_grant_data} : r_tdata;
    end else begin
      r_tvalid <= r_tvalid;
      r_tdata  <= r_tdata;
    end
  end

  assign axis_tvalid_o = r_tvalid;
  assign axis_tdata_o  = r_tdata;
  assign req_credits_o = r_req_cred;
  assign rsp_credits_o = r_rsp_cred;

`ifdef FLOO_BRIDGE_ARB_STATS_EN
  logic [31:0] r_stat_req;
  logic [31:0] r_stat_rsp;
  logic [31:0] r_stat_stall;
  logic        w_link_hs;
  logic        w_cred_stall;

  assign w_link_hs    = r_tvalid && axis_tready_i;
  assign w_cred_stall = (req_valid_i && (r_req_cred == CredZero)) ||
                        (rsp_valid_i && (r_rsp_cred == CredZero));

  // Wrapping link statistics.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stat_req   <= 32'd0;
      r_stat_rsp   <= 32'd0;
      r_stat_stall <= 32'd0;
    end else begin
      r_stat_req   <= (w_link_hs && !r_tdata[DataWidth]) ? r_stat_req + 32'd1 : r_stat_req;
      r_stat_rsp   <= (w_link_hs &&  r_tdata[DataWidth]) ? r_stat_rsp + 32'd1 : r_stat_rsp;
      r_stat_stall <= w_cred_stall ? r_stat_stall + 32'd1 : r_stat_stall;
    end
  end

  assign stat_req_beats_o    = r_stat_req;
  assign stat_rsp_beats_o    = r_stat_rsp;
  assign stat_credit_stall_o = r_stat_stall;
`endif

  floo_axis_bridge_arbiter_chk #(
    .MaxCredits (MaxCredits),
    .CntW       (CntW)
  ) u_chk (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .i_req_credit  (req_credit_i),
    .i_req_grant   (req_ready_o),
    .i_req_credits (r_req_cred),
    .i_rsp_credit  (rsp_credit_i),
    .i_rsp_grant   (rsp_ready_o),
    .i_rsp_credits (r_rsp_cred)
  );
endmodule

// File: tb/tb_floo_axis_bridge_arbiter.sv
// Self-checking bench for floo_axis_bridge_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_floo_axis_bridge_arbiter;
  localparam int DW   = 64;
  localparam int MAXC = 8;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0, rsp_valid = 1'b0, tready = 1'b0;
  logic          req_credit = 1'b0, rsp_credit = 1'b0;
  logic [DW-1:0] req_data = '0, rsp_data = '0;
  logic          req_ready, rsp_ready, tvalid;
  logic [DW:0]   tdata;
  logic [CW-1:0] req_credits, rsp_credits;

  always #5 clk = ~clk;

  floo_axis_bridge_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data),
    .rsp_valid_i(rsp_valid), .rsp_ready_o(rsp_ready), .rsp_data_i(rsp_data),
    .axis_tvalid_o(tvalid), .axis_tready_i(tready), .axis_tdata_o(tdata),
    .req_credit_i(req_credit), .rsp_credit_i(rsp_credit),
    .req_credits_o(req_credits), .rsp_credits_o(rsp_credits)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b1; rsp_valid = 1'b1; tready = 1'b1;
    req_credit = 1'b0; rsp_credit = 1'b0;
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_ready", rsp_ready, 0);
    @(posedge clk); #1;
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_req_credits", req_credits, MAXC);
    check("rst_rsp_credits", rsp_credits, MAXC);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0; rsp_valid = 1'b0;
  endtask

  typedef struct {
    logic rv, sv, tr, rc, sc;
    logic e_rrdy, e_srdy, e_tvalid, e_hdr;
    int   e_rcred, e_scred;
  } vec_t;
  vec_t vt[$];

  // Reference model state: link register contents, credit counts, owner and run length.
  int          m_cred[2];
  int          m_owner, m_run;
  bit          m_valid;
  logic [DW:0] m_data;
  int          quota[2] = '{4, 4};

  function automatic int pick(bit v0, bit v1);
    bit e0, e1;
    e0 = v0 && (m_cred[0] > 0);
    e1 = v1 && (m_cred[1] > 0);
    if (e0 && e1) return (m_run < quota[m_owner]) ? m_owner : 1 - m_owner;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  logic [DW:0] exp_q[$];
  logic [DW:0] held, popped;
  bit          hs, stall, rv, sv, tr, pc[2];
  int          beat_k, n_rsp, g;

  initial begin
    // ---------------- table: req-only drain, refill, same-cycle grant+credit, saturation
    for (int k = 0; k < 8; k++) vt.push_back('{1,0,1,0,0, 1,0,1,0, 7-k, 8});
    vt.push_back('{1,0,1,0,0, 0,0,0,0, 0, 8});
    vt.push_back('{1,0,1,1,0, 0,0,0,0, 1, 8});
    vt.push_back('{1,0,1,0,0, 1,0,1,0, 0, 8});
    for (int k = 1; k <= 3; k++) vt.push_back('{0,0,1,1,0, 0,0,0,0, k, 8});
    vt.push_back('{1,0,1,1,0, 1,0,1,0, 3, 8});
    for (int k = 4; k <= 8; k++) vt.push_back('{0,0,1,1,0, 0,0,0,0, k, 8});
    vt.push_back('{0,0,1,1,0, 0,0,0,0, 8, 8});
    vt.push_back('{0,1,1,0,1, 0,1,1,1, 8, 8});
    vt.push_back('{0,0,1,0,0, 0,0,0,0, 8, 8});

    do_reset();
    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      req_valid = vt[i].rv; rsp_valid = vt[i].sv; tready = vt[i].tr;
      req_credit = vt[i].rc; rsp_credit = vt[i].sc;
      req_data = 64'hAAAA_0000_0000_0000 + 64'(i); rsp_data = 64'h5555_0000_0000_0000 + 64'(i);
      #1;
      check($sformatf("vec%0d_req_ready", i), req_ready, vt[i].e_rrdy);
      check($sformatf("vec%0d_rsp_ready", i), rsp_ready, vt[i].e_srdy);
      @(posedge clk); #1;
      check($sformatf("vec%0d_tvalid", i), tvalid, vt[i].e_tvalid);
      if (vt[i].e_tvalid) check($sformatf("vec%0d_hdr", i), tdata[DW], vt[i].e_hdr);
      check($sformatf("vec%0d_req_credits", i), req_credits, vt[i].e_rcred);
      check($sformatf("vec%0d_rsp_credits", i), rsp_credits, vt[i].e_scred);
    end

    // ---------------- both valid, credits refilled, tready stall mid-burst
    do_reset();
    exp_q.delete();
    beat_k = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      stall = (c >= 10) && (c < 15);
      req_valid = 1'b1; rsp_valid = 1'b1; tready = !stall;
      req_credit = 1'b0; rsp_credit = 1'b0;
      req_data = {32'hAAAA_0000, 32'(c)}; rsp_data = {32'h5555_0000, 32'(c)};
      #1;
      req_credit = req_ready; rsp_credit = rsp_ready;
      if (stall) begin
        check("stall_req_ready", req_ready, 0);
        check("stall_rsp_ready", rsp_ready, 0);
      end
      hs = tvalid && tready;
      held = tdata;
      if (hs) begin
        check("wrr_sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          popped = exp_q.pop_front();
          check($sformatf("wrr_beat%0d_data", beat_k), held, popped);
        end
        check($sformatf("wrr_beat%0d_hdr", beat_k), held[DW], (beat_k / 4) % 2);
        beat_k++;
      end
      if (req_ready) exp_q.push_back({1'b0, req_data});
      if (rsp_ready) exp_q.push_back({1'b1, rsp_data});
      @(posedge clk); #1;
      check("wrr_no_bubble", tvalid, 1);
      if (stall) check("stall_tdata_stable", tdata, held);
    end
    check("wrr_beats_seen", beat_k >= 20, 1);

    // ---------------- rsp credits exhausted: req takes every slot, one credit gives one rsp beat
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      req_valid = 1'b0; rsp_valid = 1'b1; tready = 1'b1; req_credit = 1'b0; rsp_credit = 1'b0;
      @(posedge clk);
    end
    #1;
    check("drain_rsp_credits", rsp_credits, 0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req_valid = 1'b1; rsp_valid = 1'b1; rsp_credit = 1'b0;
      #1;
      check("nocred_req_ready", req_ready, 1);
      check("nocred_rsp_ready", rsp_ready, 0);
      req_credit = req_ready;
      @(posedge clk);
    end
    @(negedge clk);
    rsp_credit = 1'b1;
    #1;
    check("pulse_rsp_ready", rsp_ready, 0);
    req_credit = req_ready;
    @(posedge clk);
    n_rsp = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      rsp_credit = 1'b0;
      #1;
      req_credit = req_ready;
      if (rsp_ready) n_rsp++;
      @(posedge clk);
    end
    check("one_credit_one_rsp", n_rsp, 1);

    // ---------------- reset while a beat is held
    @(negedge clk);
    rst = 1'b1; req_credit = 1'b0; rsp_credit = 1'b0;
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0; rsp_valid = 1'b1; tready = 1'b0;
    @(posedge clk); #1;
    check("held_tvalid", tvalid, 1);
    check("held_hdr", tdata[DW], 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_rsp_ready", rsp_ready, 0);
    @(posedge clk); #1;
    check("midrst_tvalid", tvalid, 0);
    check("midrst_req_credits", req_credits, MAXC);
    check("midrst_rsp_credits", rsp_credits, MAXC);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b1; rsp_valid = 1'b1; tready = 1'b1;
    #1;
    check("postrst_req_ready", req_ready, 1);
    check("postrst_rsp_ready", rsp_ready, 0);
    @(posedge clk);

    // ---------------- randomized run against the reference model
    do_reset();
    m_cred[0] = MAXC; m_cred[1] = MAXC; m_owner = 0; m_run = 0; m_valid = 1'b0; m_data = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rv = ($urandom_range(0, 9) < 7);
      sv = ($urandom_range(0, 9) < 7);
      tr = ($urandom_range(0, 3) != 0);
      pc[0] = (m_cred[0] < MAXC) && ($urandom_range(0, 2) == 0);
      pc[1] = (m_cred[1] < MAXC) && ($urandom_range(0, 2) == 0);
      req_valid = rv; rsp_valid = sv; tready = tr;
      req_credit = pc[0]; rsp_credit = pc[1];
      req_data = {$urandom, $urandom}; rsp_data = {$urandom, $urandom};
      #1;
      g = (!m_valid || tr) ? pick(rv, sv) : -1;
      check("rnd_req_ready", req_ready, g == 0);
      check("rnd_rsp_ready", rsp_ready, g == 1);
      if (!m_valid || tr) begin
        m_valid = (g >= 0);
        if (g == 0) m_data = {1'b0, req_data};
        if (g == 1) m_data = {1'b1, rsp_data};
      end
      for (int ch = 0; ch < 2; ch++) begin
        if ((g == ch) && !pc[ch]) m_cred[ch]--;
        else if (pc[ch] && (g != ch) && (m_cred[ch] < MAXC)) m_cred[ch]++;
      end
      if (g >= 0) begin
        if (g == m_owner) m_run++;
        else begin
          m_owner = g;
          m_run = 1;
        end
      end
      @(posedge clk); #1;
      check("rnd_tvalid", tvalid, m_valid);
      if (m_valid) check("rnd_tdata", tdata, m_data);
      check("rnd_req_credits", req_credits, m_cred[0]);
      check("rnd_rsp_credits", rsp_credits, m_cred[1]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
